aes_key_schedule_ctrl: RTL

Sequencing controller that drives the single-round KeyExpansion datapath over all AES-128 rounds. It accepts a cipher key, iterates the datapath once per clock to build all 11 round keys, and holds them in a local key buffer. A registered read port then serves round keys by index to the cipher round engine. It sits between the key-load interface and the round engine, so the engine never waits on key expansion per round.

---
 rtl/aes_key_schedule_ctrl_if.sv | 28 ++
 rtl/aes_key_schedule_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_ctrl_if.sv
// Key-load and round-key read bus between the key source / round engine and the schedule controller.
interface aes_key_schedule_ctrl_if #(
  parameter int unsigned NB = 128
);
  logic [NB-1:0] KeyIn;
  logic          KeyValid;
  logic          KeyReady;
  logic          Busy;
  logic          Done;
  logic          KeysReady;
  logic          RkReq;
  logic [3:0]    RkIndex;
  logic [NB-1:0] RkOut;
  logic          RkValid;
  logic          RkErr;

  // Side that loads keys and requests round keys
  modport master (
    output KeyIn, KeyValid, RkReq, RkIndex,
    input  KeyReady, Busy, Done, KeysReady, RkOut, RkValid, RkErr
  );

  // Schedule controller side
  modport slave (
    input  KeyIn, KeyValid, RkReq, RkIndex,
    output KeyReady, Busy, Done, KeysReady, RkOut, RkValid, RkErr
  );
endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key schedule controller: expands a cipher key into 11 round keys
// (one round per clock) and serves them through a registered read port.

// Single AES-128 KeyExpansion round: RoundKey[r] -> RoundKey[r+1].
// Words are little-endian in bytes: byte i of the key sits at bits [8i+7:8i].
module aes_key_expand_round (
  input  logic [127:0] round_key,
  input  logic [3:0]   round_number,
  output logic [127:0] next_round_key
);
  localparam int unsigned WW = 32;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] sh;
    p  = 8'h00;
    sh = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254) followed by the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for the round being produced (round_number + 1)
  function automatic logic [7:0] rcon(input logic [3:0] rn);
    case (rn)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [WW-1:0] rot;
  logic [WW-1:0] sub;
  logic [WW-1:0] t;
  logic [WW-1:0] n0, n1, n2, n3;

  // RotWord/SubWord/Rcon on word 3, then chain the XORs through words 0..3
  always_comb begin
    rot = {round_key[103:96], round_key[127:104]};
    sub = '0;
    for (int j = 0; j < 4; j++) begin
      sub[8*j +: 8] = sbox(rot[8*j +: 8]);
    end
    t  = sub ^ {24'h000000, rcon(round_number)};
    n0 = round_key[31:0]   ^ t;
    n1 = round_key[63:32]  ^ n0;
    n2 = round_key[95:64]  ^ n1;
    n3 = round_key[127:96] ^ n2;
    next_round_key = {n3, n2, n1, n0};
  end
endmodule

module aes_key_schedule_ctrl #(
  parameter int unsigned NB = 128,
  parameter int unsigned NR = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  aes_key_schedule_ctrl_if.slave bus
);
  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] round_cnt;
  logic [NB-1:0] key_buf [NR+1];
  logic [NB-1:0] next_key;
  logic          key_ready;
  logic          busy;
  logic          done;
  logic          keys_ready;
  logic [NB-1:0] rk_out;
  logic          rk_valid;
  logic          rk_err;
  logic          rd_oob;

  aes_key_expand_round u_round (
    .round_key      (key_buf[round_cnt]),
    .round_number   (round_cnt),
    .next_round_key (next_key)
  );

  assign rd_oob = (bus.RkIndex > IW'(NR));

  // Controller FSM, key buffer and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round_cnt  <= '0;
      for (int unsigned i = 0; i <= NR; i++) key_buf[i] <= '0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_ready <= 1'b0;
      rk_out     <= '0;
      rk_valid   <= 1'b0;
      rk_err     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.KeyValid) begin
            key_buf[0] <= bus.KeyIn;
            round_cnt  <= '0;
            state      <= EXPAND;
            busy       <= 1'b1;
            key_ready  <= 1'b0;
          end
        end
        EXPAND: begin
          key_buf[round_cnt + IW'(1)] <= next_key;
          round_cnt                   <= round_cnt + IW'(1);
          if (round_cnt == IW'(NR - 1)) begin
            state      <= READY;
            busy       <= 1'b0;
            key_ready  <= 1'b1;
            done       <= 1'b1;
            keys_ready <= 1'b1;
          end
        end
        READY: begin
          // Read samples the buffer before any same-edge reload overwrites it
          if (bus.RkReq) begin
            rk_valid <= 1'b1;
            rk_err   <= rd_oob;
            rk_out   <= rd_oob ? '0 : key_buf[bus.RkIndex];
          end
          if (bus.KeyValid) begin
            key_buf[0] <= bus.KeyIn;
            round_cnt  <= '0;
            state      <= EXPAND;
            busy       <= 1'b1;
            key_ready  <= 1'b0;
            keys_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.KeyReady  = key_ready;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.KeysReady = keys_ready;
  assign bus.RkOut     = rk_out;
  assign bus.RkValid   = rk_valid;
  assign bus.RkErr     = rk_err;
endmodule
